// File: rtl/mc_control.sv
// Multicycle MIPS32 control FSM: sequences fetch/decode/execute/memory/write-back
// and drives every datapath select, write enable and the ALU operation code.
module mc_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic [2:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] ext_op,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       ovf_trap,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEM_ADR = 4'd2,
    MEM_RD  = 4'd3,
    MEM_WB  = 4'd4,
    MEM_WR  = 4'd5,
    EXEC    = 4'd6,
    ALU_WB  = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  state_t cur, nxt;
  logic   ovf_flag;
  logic   is_rtype, r_ok, is_addi, is_mem, is_alu_i;

  assign is_rtype = (op == OP_RTYPE);
  assign r_ok     = is_rtype && (funct == FN_ADDU || funct == FN_SUBU || funct == FN_SLT);
  assign is_addi  = (op == OP_ADDI);
  assign is_mem   = (op == OP_LW) || (op == OP_SW);
  assign is_alu_i = is_addi || (op == OP_ADDIU) || (op == OP_ORI) || (op == OP_LUI);
  assign state    = cur;

  // ovf_flag only ever carries an addi overflow from EXEC into the following ALU_WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= FETCH;
      ovf_flag <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == DECODE)
        ovf_flag <= 1'b0;
      else if (cur == EXEC)
        ovf_flag <= is_addi & overflow;
    end
  end

  always_comb begin
    nxt        = FETCH;
    alu_op     = 3'b000;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_op     = 2'b00;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    iord       = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    ovf_trap   = 1'b0;
    illegal    = 1'b0;
    case (cur)
      FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
        nxt       = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        ext_op    = 2'b01;
        if (is_mem)                     nxt = MEM_ADR;
        else if (r_ok || is_alu_i)      nxt = EXEC;
        else if (op == OP_BEQ)          nxt = BRANCH;
        else if (op == OP_J)            nxt = JUMP;
        else begin
          illegal = 1'b1;
          nxt     = FETCH;
        end
      end
      MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op    = 2'b01;
        nxt       = (op == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        iord = 1'b1;
        nxt  = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      // Every EXEC operation uses reg A; only the B operand and extension differ.
      EXEC: begin
        alu_src_a = 1'b1;
        nxt       = ALU_WB;
        if (is_rtype) begin
          alu_src_b = 2'b00;
          case (funct)
            FN_SUBU: alu_op = 3'b001;
            FN_SLT:  alu_op = 3'b011;
            default: alu_op = 3'b000;
          endcase
        end else begin
          alu_src_b = 2'b10;
          case (op)
            OP_ADDI: begin ext_op = 2'b01; alu_op = 3'b100; end
            OP_ORI:  begin ext_op = 2'b00; alu_op = 3'b010; end
            OP_LUI:  begin ext_op = 2'b10; alu_op = 3'b010; end
            default: begin ext_op = 2'b01; alu_op = 3'b000; end
          endcase
        end
      end
      ALU_WB: begin
        reg_dst   = is_rtype;
        reg_write = ~ovf_flag;
        ovf_trap  = ovf_flag;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b001;
        pc_src    = 2'b01;
        pc_write  = zero;
      end
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: nxt = FETCH;
    endcase

    // Reset presents FETCH selects with every enable and pulse held low.
    if (rst) begin
      alu_op     = 3'b000;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b01;
      ext_op     = 2'b00;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      iord       = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      ovf_trap   = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule
